// File: rtl/fifo_arb_pkg.sv
// Shared state encoding and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Ceiling-log2 that never collapses to a zero-width vector.
    function automatic int clog2_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after 'last', wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = clog2_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Offset NUM_REQ wraps back to 'last' itself, so it has the lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          full,
    output logic                          w_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);

    localparam int OWNER_W = $clog2(NUM_REQ);
    localparam int CNT_W   = clog2_w(MAX_BURST + 1);

    state_t             state_reg, state_next;
    logic [OWNER_W-1:0] owner_reg;
    logic [CNT_W-1:0]   burst_cnt_reg;
    logic               pick_valid;
    logic [OWNER_W-1:0] pick_idx;
    logic               xfer;
    logic               last_word;
    logic [DATA_WIDTH-1:0] slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWNER_W)
    ) u_rr_pick (
        .req   (req),
        .last  (owner_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign xfer      = (state_reg == GRANT) && req[owner_reg] && !full;
    assign last_word = (burst_cnt_reg == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                // A dropped request ends the burst; full with a live request just stalls.
                if (!req[owner_reg]) begin
                    state_next = IDLE;
                end else if (!full && last_word) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            owner_reg     <= OWNER_W'(NUM_REQ - 1);
            burst_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (pick_valid) begin
                owner_reg     <= pick_idx;
                burst_cnt_reg <= '0;
            end
        end else if (xfer) begin
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        w_en    = xfer;
        gnt     = '0;
        data_in = '0;
        if (xfer) begin
            gnt[owner_reg] = 1'b1;
            data_in        = slice[owner_reg];
        end
    end

    assign owner = owner_reg;
    assign busy  = (state_reg == GRANT);

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing the FIFO write port (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: word width, equal to the FIFO DATA_WIDTH.
REQ-003 The block SHALL have parameter MAX_BURST, default 4: maximum number of words per grant (1..256).
REQ-004 The block SHALL have port wclk, input, 1 bit: the single clock, which is the FIFO write clock.
REQ-005 The block SHALL have port wrst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: bit i means requester i holds a valid word.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*DATA_WIDTH bits: the word of requester i sits in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port gnt, output, NUM_REQ bits: one-hot; bit i means the word of requester i is accepted this cycle.
REQ-009 The block SHALL have port full, input, 1 bit: the FIFO full flag in the wclk domain.
REQ-010 The block SHALL have port w_en, output, 1 bit: FIFO write enable.
REQ-011 The block SHALL have port data_in, output, DATA_WIDTH bits: FIFO write data.
REQ-012 The block SHALL have port owner, output, $clog2(NUM_REQ) bits: index of the current or most recent grantee.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in GRANT.

Function
REQ-014 The FSM SHALL have two states: IDLE and GRANT.
REQ-015 In IDLE with any req bit set, the block SHALL select the first set bit searching from owner+1 upward, modulo NUM_REQ, then register owner, clear burst_cnt and enter GRANT on the next edge.
REQ-016 In IDLE with req all zero, the block SHALL remain in IDLE and hold owner.
REQ-017 A transfer SHALL occur in any cycle with GRANT && req[owner] && !full.
REQ-018 During a transfer, w_en SHALL be 1, gnt SHALL equal 1<<owner, and data_in SHALL equal the owner slice of req_data.
REQ-019 Outside a transfer, w_en and gnt SHALL be 0 and data_in SHALL be 0.
REQ-020 w_en, gnt and data_in SHALL be combinational from state, owner, req, full and req_data, so there is zero latency from req to write within GRANT.
REQ-021 burst_cnt SHALL increment on each transfer, with width $clog2(MAX_BURST+1).
REQ-022 A transfer with burst_cnt == MAX_BURST-1 SHALL return the FSM to IDLE on the next edge.
REQ-023 GRANT with req[owner]=0 SHALL return the FSM to IDLE on the next edge with no transfer; the requester abandons the remainder of its burst.
REQ-024 GRANT with full=1 and req[owner]=1 SHALL stall: state, owner and burst_cnt are held, and the block stays in GRANT indefinitely.
REQ-025 Req bits of non-owners SHALL be ignored in GRANT.
REQ-026 Every grant SHALL be followed by exactly one IDLE arbitration cycle; no back-to-back grants.
REQ-027 Under continuous requests, no requester SHALL wait more than NUM_REQ-1 grants (round-robin fairness).
REQ-028 Requesters SHALL hold req and req_data stable until gnt; the block does not latch data.

Reset
REQ-029 While wrst_n=0, the block SHALL force state=IDLE, owner=NUM_REQ-1, burst_cnt=0, busy=0, w_en=0, gnt=0 and data_in=0, asynchronously and without waiting for wclk.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately, with no write on the reset cycle.
REQ-031 After reset release, the first arbitration SHALL give requester 0 top priority.

Structure
REQ-032 A shared package fifo_arb_pkg SHALL hold the state encoding (IDLE=0, GRANT=1) and the ceiling-log2 width helper constants.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_pick with inputs req and last and outputs valid and idx.
REQ-034 The top level SHALL contain only the FSM, the counter and the write mux.

Verification
REQ-035 Reset test: wrst_n=0 with req=4'b1111 SHALL give w_en=0, gnt=0, busy=0 and owner=3; then release wrst_n SHALL give busy=1 on the next edge with owner=0.
REQ-036 Single-requester test: req=4'b0010 held for 10 cycles, full=0, MAX_BURST=4 SHALL give owner=1, gnt=4'b0010 for 4 consecutive cycles, one IDLE cycle, then 4 more transfers.
REQ-037 Round-robin test: req=4'b1111 held SHALL give grant order 0,1,2,3,0 with 4 words each and a one-cycle gap between grants.
REQ-038 Backpressure test: full=1 for 3 cycles after the 2nd word of a burst SHALL give w_en=0 and busy=1 for those 3 cycles, then exactly 2 more words, then IDLE.
REQ-039 Abandon test: requester 2 drops req after 1 word while req[3]=1 SHALL give IDLE next, then owner=3.
REQ-040 Mid-burst reset test: wrst_n=0 pulsed after the 2nd word SHALL give w_en=0 in the same cycle and owner=3; after release, requester 0 wins if requesting.
